// File: rtl/lsu_if.sv
// Execute-side, memory and writeback bus bundle for the lsu.
// Optional misalign_o exists only when LSU_MISALIGN_TRAP_EN is defined.
interface lsu_if #(
  parameter int unsigned Xlen = 64
);
  localparam int unsigned Nb = Xlen / 8;

  logic            valid_i;
  logic            ready_o;
  logic            store_i;
  logic [2:0]      funct3_i;
  logic [Xlen-1:0] addr_i;
  logic [Xlen-1:0] wdata_i;
  logic [4:0]      rd_i;
  logic            mem_valid_o;
  logic            mem_ready_i;
  logic            mem_we_o;
  logic [Xlen-1:0] mem_addr_o;
  logic [Xlen-1:0] mem_wdata_o;
  logic [Nb-1:0]   mem_wmask_o;
  logic            mem_rvalid_i;
  logic [Xlen-1:0] mem_rdata_i;
  logic            wb_valid_o;
  logic            wb_ready_i;
  logic            wb_we_o;
  logic [4:0]      wb_rd_o;
  logic [Xlen-1:0] wb_data_o;
`ifdef LSU_MISALIGN_TRAP_EN
  logic            misalign_o;
`endif

  modport slave (
    input  valid_i, store_i, funct3_i, addr_i, wdata_i, rd_i,
    input  mem_ready_i, mem_rvalid_i, mem_rdata_i, wb_ready_i,
    output ready_o, mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    output wb_valid_o, wb_we_o, wb_rd_o, wb_data_o
`ifdef LSU_MISALIGN_TRAP_EN
    , output misalign_o
`endif
  );

  modport master (
    output valid_i, store_i, funct3_i, addr_i, wdata_i, rd_i,
    output mem_ready_i, mem_rvalid_i, mem_rdata_i, wb_ready_i,
    input  ready_o, mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    input  wb_valid_o, wb_we_o, wb_rd_o, wb_data_o
`ifdef LSU_MISALIGN_TRAP_EN
    , input misalign_o
`endif
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one memory access in flight, lane alignment and load extension.
// Define LSU_MISALIGN_TRAP_EN to report misaligned accesses instead of rounding them down.
module lsu #(
  parameter int unsigned Xlen = 64
) (
  input logic  clk_i,
  input logic  rst_ni,
  lsu_if.slave bus
);
  localparam int unsigned Nb = Xlen / 8;
  localparam int unsigned Ob = $clog2(Nb);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e          r_state;
  logic            r_store;
  logic [1:0]      r_size;
  logic            r_uns;
  logic [Ob-1:0]   r_off;
  logic [4:0]      r_rd;
  logic            r_mem_valid;
  logic            r_mem_we;
  logic [Xlen-1:0] r_mem_addr;
  logic [Xlen-1:0] r_mem_wdata;
  logic [Nb-1:0]   r_mem_wmask;
  logic            r_wb_valid;
  logic            r_wb_we;
  logic [4:0]      r_wb_rd;
  logic [Xlen-1:0] r_wb_data;
`ifdef LSU_MISALIGN_TRAP_EN
  logic            r_misalign;
`endif

  logic [1:0]      w_size;
  int unsigned     w_bytes;
  logic [Xlen-1:0] w_align_mask;
  logic            w_misalign;
  logic [Xlen-1:0] w_eff;
  logic [Ob-1:0]   w_off;
  logic [Nb-1:0]   w_lane;
  logic [Xlen-1:0] w_mem_addr;
  logic [Nb-1:0]   w_mask;
  logic [Xlen-1:0] w_wdata;
  logic [Xlen-1:0] w_shift;
  int unsigned     w_rbits;
  logic            w_sign;
  logic [Xlen-1:0] w_ext;

  // Request-side decode from the incoming access.
  always_comb begin
    w_size = bus.funct3_i[1:0];
    // Doubleword encodings degrade to word accesses on a 32-bit datapath.
    if (Xlen == 32 && w_size == 2'd3) w_size = 2'd2;
    w_bytes      = 32'd1 << w_size;
    w_align_mask = Xlen'(w_bytes - 32'd1);
    w_misalign   = |(bus.addr_i & w_align_mask);
    w_eff        = bus.addr_i & ~w_align_mask;
    w_off        = w_eff[Ob-1:0];
    w_lane       = '0;
    for (int unsigned i = 0; i < Nb; i++) w_lane[i] = (i < w_bytes);
    w_mask     = w_lane << w_off;
    w_wdata    = bus.wdata_i << {w_off, 3'b000};
    w_mem_addr = {w_eff[Xlen-1:Ob], {Ob{1'b0}}};
  end

  // Load data extraction from the captured offset and size.
  always_comb begin
    w_shift = bus.mem_rdata_i >> {r_off, 3'b000};
    w_rbits = 32'd8 << r_size;
    w_sign  = 1'b0;
    for (int unsigned i = 0; i < Xlen; i++) begin
      if (i == w_rbits - 32'd1) w_sign = w_shift[i] & ~r_uns;
    end
    w_ext = '0;
    for (int unsigned i = 0; i < Xlen; i++) w_ext[i] = (i < w_rbits) ? w_shift[i] : w_sign;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= StIdle;
      r_store     <= 1'b0;
      r_size      <= '0;
      r_uns       <= 1'b0;
      r_off       <= '0;
      r_rd        <= '0;
      r_mem_valid <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wmask <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_we     <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_data   <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      r_misalign  <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.valid_i) begin
            r_store <= bus.store_i;
            r_size  <= w_size;
            r_uns   <= bus.funct3_i[2];
            r_off   <= w_off;
            r_rd    <= bus.rd_i;
`ifdef LSU_MISALIGN_TRAP_EN
            if (w_misalign) begin
              r_state    <= StResp;
              r_wb_valid <= 1'b1;
              r_wb_we    <= 1'b0;
              r_wb_rd    <= '0;
              r_wb_data  <= bus.addr_i;
              r_misalign <= 1'b1;
            end else begin
`else
            begin
`endif
              r_state     <= StReq;
              r_mem_valid <= 1'b1;
              r_mem_we    <= bus.store_i;
              r_mem_addr  <= w_mem_addr;
              r_mem_wdata <= w_wdata;
              r_mem_wmask <= w_mask;
            end
          end
        end
        StReq: begin
          if (bus.mem_ready_i) begin
            r_mem_valid <= 1'b0;
            if (r_store) begin
              r_state    <= StResp;
              r_wb_valid <= 1'b1;
              r_wb_we    <= 1'b0;
              r_wb_rd    <= '0;
              r_wb_data  <= '0;
            end else begin
              r_state <= StWait;
            end
          end
        end
        StWait: begin
          if (bus.mem_rvalid_i) begin
            r_state    <= StResp;
            r_wb_valid <= 1'b1;
            r_wb_we    <= 1'b1;
            r_wb_rd    <= r_rd;
            r_wb_data  <= w_ext;
          end
        end
        StResp: begin
          if (bus.wb_ready_i) begin
            r_state    <= StIdle;
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            r_misalign <= 1'b0;
`endif
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifndef LSU_MISALIGN_TRAP_EN
  logic w_unused;
  assign w_unused = w_misalign;
`endif

  assign bus.ready_o     = (r_state == StIdle);
  assign bus.mem_valid_o = r_mem_valid;
  assign bus.mem_we_o    = r_mem_we;
  assign bus.mem_addr_o  = r_mem_addr;
  assign bus.mem_wdata_o = r_mem_wdata;
  assign bus.mem_wmask_o = r_mem_wmask;
  assign bus.wb_valid_o  = r_wb_valid;
  assign bus.wb_we_o     = r_wb_we;
  assign bus.wb_rd_o     = r_wb_rd;
  assign bus.wb_data_o   = r_wb_data;
`ifdef LSU_MISALIGN_TRAP_EN
  assign bus.misalign_o  = r_misalign;
`endif
endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu (Xlen = 64): directed vector table, corner sequences
// and random accesses checked against an arithmetic reference model.
module tb_lsu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   wr_cnt = 0;

  lsu_if #(.Xlen(64)) bus ();

  lsu #(.Xlen(64)) u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && bus.mem_valid_o && bus.mem_ready_i && bus.mem_we_o) wr_cnt++;
  end

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wd;
    logic [63:0] rdata;
    logic [63:0] e_addr;
    logic [63:0] e_wdata;
    logic [7:0]  e_mask;
    logic [63:0] e_wb;
  } vec_t;

  vec_t tbl[10];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: spec rules computed with plain arithmetic on wide integers.
  task automatic model(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wd, input logic [63:0] rdata,
                       output logic [63:0] e_addr, output logic [63:0] e_wdata,
                       output logic [7:0] e_mask, output logic [63:0] e_wb);
    logic [1:0]   sz;
    int unsigned  bytes;
    int unsigned  off;
    logic [63:0]  a;
    logic [127:0] w;
    logic [127:0] v;
    logic [127:0] span;
    sz     = f3[1:0];
    bytes  = 1 << sz;
    a      = addr - (addr % 64'(bytes));
    off    = 32'(a % 64'd8);
    e_addr = a - 64'(off);
    w      = {64'd0, wd} << (8 * off);
    e_wdata = w[63:0];
    e_mask = 8'(((1 << bytes) - 1) << off);
    span   = 128'd1 << (8 * bytes);
    v      = ({64'd0, rdata} >> (8 * off)) % span;
    if (!f3[2] && v >= (span >> 1)) v = v - span;
    e_wb = st ? 64'd0 : v[63:0];
  endtask

  task automatic access(input string tag, input logic st, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wd,
                        input logic [63:0] rdata, input logic [4:0] rd,
                        input int mw, input int ww, input logic [63:0] e_addr,
                        input logic [63:0] e_wdata, input logic [7:0] e_mask,
                        input logic [63:0] e_wb);
    int cyc;
    for (int k = 0; k < 20 && !bus.ready_o; k++) begin
      bus.wb_ready_i = 1'b1;
      tick();
    end
    bus.wb_ready_i = 1'b0;
    chk({tag, " ready_idle"}, 64'(bus.ready_o), 64'd1);
    bus.valid_i  = 1'b1;
    bus.store_i  = st;
    bus.funct3_i = f3;
    bus.addr_i   = addr;
    bus.wdata_i  = wd;
    bus.rd_i     = rd;
    tick();
    bus.valid_i = 1'b0;
    bus.addr_i  = ~addr;
    bus.wdata_i = ~wd;
    cyc = 1;
    chk({tag, " mem_valid"}, 64'(bus.mem_valid_o), 64'd1);
    chk({tag, " mem_we"}, 64'(bus.mem_we_o), 64'(st));
    chk({tag, " mem_addr"}, bus.mem_addr_o, e_addr);
    if (st) begin
      chk({tag, " mem_wdata"}, bus.mem_wdata_o, e_wdata);
      chk({tag, " mem_wmask"}, 64'(bus.mem_wmask_o), 64'(e_mask));
    end
    for (int k = 0; k < mw; k++) begin
      tick();
      cyc++;
      chk({tag, " req_hold_valid"}, 64'(bus.mem_valid_o), 64'd1);
      chk({tag, " req_hold_addr"}, bus.mem_addr_o, e_addr);
      if (st) chk({tag, " req_hold_wdata"}, bus.mem_wdata_o, e_wdata);
      chk({tag, " req_hold_ready"}, 64'(bus.ready_o), 64'd0);
    end
    bus.mem_ready_i = 1'b1;
    tick();
    cyc++;
    bus.mem_ready_i = 1'b0;
    if (!st) begin
      chk({tag, " wait_no_req"}, 64'(bus.mem_valid_o), 64'd0);
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = rdata;
      tick();
      cyc++;
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i  = {$urandom, $urandom};
    end
    for (int k = 0; k < 10 && !bus.wb_valid_o; k++) begin
      tick();
      cyc++;
    end
    chk({tag, " wb_valid"}, 64'(bus.wb_valid_o), 64'd1);
    chk({tag, " latency"}, 64'(cyc), 64'((st ? 2 : 3) + mw));
    chk({tag, " wb_we"}, 64'(bus.wb_we_o), 64'(!st));
    chk({tag, " wb_rd"}, 64'(bus.wb_rd_o), st ? 64'd0 : 64'(rd));
    chk({tag, " wb_data"}, bus.wb_data_o, e_wb);
`ifdef LSU_MISALIGN_TRAP_EN
    chk({tag, " misalign"}, 64'(bus.misalign_o), 64'd0);
`endif
    for (int k = 0; k < ww; k++) begin
      tick();
      chk({tag, " wb_hold_valid"}, 64'(bus.wb_valid_o), 64'd1);
      chk({tag, " wb_hold_data"}, bus.wb_data_o, e_wb);
      chk({tag, " wb_hold_ready"}, 64'(bus.ready_o), 64'd0);
    end
    bus.wb_ready_i = 1'b1;
    tick();
    bus.wb_ready_i = 1'b0;
    chk({tag, " wb_done"}, 64'(bus.wb_valid_o), 64'd0);
    chk({tag, " ready_back"}, 64'(bus.ready_o), 64'd1);
  endtask

  initial begin
    logic [63:0] ea, ew, eb;
    logic [7:0]  em;
    logic        st;
    logic [2:0]  f3;
    logic [63:0] addr;
    int          w0;

    tbl[0] = '{1'b0, 3'd2, 64'h1004, 64'h0, 64'h8000_0001_0000_0000,
               64'h1000, 64'h0, 8'h00, 64'hFFFF_FFFF_8000_0001};
    tbl[1] = '{1'b0, 3'd4, 64'h2003, 64'h0, 64'h1122_3344_F0AA_BBCC,
               64'h2000, 64'h0, 8'h00, 64'h0000_0000_0000_00F0};
    tbl[2] = '{1'b0, 3'd0, 64'h2003, 64'h0, 64'h1122_3344_F0AA_BBCC,
               64'h2000, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FFF0};
    tbl[3] = '{1'b1, 3'd1, 64'h300A, 64'h1234, 64'h0,
               64'h3008, 64'h0000_0000_1234_0000, 8'b0000_1100, 64'h0};
    tbl[4] = '{1'b0, 3'd3, 64'h4008, 64'h0, 64'hDEAD_BEEF_0123_4567,
               64'h4008, 64'h0, 8'h00, 64'hDEAD_BEEF_0123_4567};
    tbl[5] = '{1'b1, 3'd0, 64'h6007, 64'hAB, 64'h0,
               64'h6000, 64'hAB00_0000_0000_0000, 8'h80, 64'h0};
    tbl[6] = '{1'b1, 3'd3, 64'h7000, 64'h0102_0304_0506_0708, 64'h0,
               64'h7000, 64'h0102_0304_0506_0708, 8'hFF, 64'h0};
    tbl[7] = '{1'b0, 3'd6, 64'h1004, 64'h0, 64'h8000_0001_0000_0000,
               64'h1000, 64'h0, 8'h00, 64'h0000_0000_8000_0001};
    tbl[8] = '{1'b0, 3'd1, 64'h800E, 64'h0, 64'h8001_0000_0000_0000,
               64'h8008, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_8001};
    tbl[9] = '{1'b0, 3'd5, 64'h900C, 64'h0, 64'h0000_8001_0000_0000,
               64'h9008, 64'h0, 8'h00, 64'h0000_0000_0000_8001};

    bus.valid_i = 1'b0; bus.store_i = 1'b0; bus.funct3_i = '0; bus.addr_i = '0;
    bus.wdata_i = '0; bus.rd_i = '0; bus.mem_ready_i = 1'b0; bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i = '0; bus.wb_ready_i = 1'b0;

    #12;
    chk("rst mem_valid", 64'(bus.mem_valid_o), 64'd0);
    chk("rst wb_valid", 64'(bus.wb_valid_o), 64'd0);
    chk("rst mem_addr", bus.mem_addr_o, 64'd0);
    chk("rst wb_data", bus.wb_data_o, 64'd0);
    chk("rst ready", 64'(bus.ready_o), 64'd1);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      access($sformatf("vec%0d", i), tbl[i].st, tbl[i].f3, tbl[i].addr, tbl[i].wd,
             tbl[i].rdata, 5'(i + 3), 0, 0, tbl[i].e_addr, tbl[i].e_wdata,
             tbl[i].e_mask, tbl[i].e_wb);
    end

    // Back-pressure on both sides: one write only.
    w0 = wr_cnt;
    access("bp", 1'b1, 3'd3, 64'hA000, 64'hCAFE_BABE_1234_5678, 64'h0, 5'd7, 3, 2,
           64'hA000, 64'hCAFE_BABE_1234_5678, 8'hFF, 64'h0);
    chk("bp write_count", 64'(wr_cnt - w0), 64'd1);

    // Reset while waiting for read data.
    bus.valid_i = 1'b1; bus.store_i = 1'b0; bus.funct3_i = 3'd3;
    bus.addr_i = 64'hB000; bus.rd_i = 5'd9;
    tick();
    bus.valid_i = 1'b0;
    bus.mem_ready_i = 1'b1;
    tick();
    bus.mem_ready_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst mem_addr", bus.mem_addr_o, 64'd0);
    chk("midrst wb_valid", 64'(bus.wb_valid_o), 64'd0);
    chk("midrst mem_valid", 64'(bus.mem_valid_o), 64'd0);
    #1;
    rst_n = 1'b1;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i = 64'h1111_2222_3333_4444;
    tick();
    bus.mem_rvalid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("midrst no_wb", 64'(bus.wb_valid_o), 64'd0);
      chk("midrst no_req", 64'(bus.mem_valid_o), 64'd0);
      tick();
    end
    chk("midrst ready", 64'(bus.ready_o), 64'd1);

`ifdef LSU_MISALIGN_TRAP_EN
    bus.valid_i = 1'b1; bus.store_i = 1'b0; bus.funct3_i = 3'd2;
    bus.addr_i = 64'h1002; bus.rd_i = 5'd4;
    tick();
    bus.valid_i = 1'b0;
    chk("trap no_req", 64'(bus.mem_valid_o), 64'd0);
    chk("trap wb_valid", 64'(bus.wb_valid_o), 64'd1);
    chk("trap misalign", 64'(bus.misalign_o), 64'd1);
    chk("trap wb_we", 64'(bus.wb_we_o), 64'd0);
    chk("trap wb_data", bus.wb_data_o, 64'h1002);
    bus.wb_ready_i = 1'b1;
    tick();
    bus.wb_ready_i = 1'b0;
    chk("trap done", 64'(bus.misalign_o), 64'd0);
`else
    access("round", 1'b0, 3'd2, 64'h1002, 64'h0, 64'h0000_0000_CAFE_F00D, 5'd4, 0, 0,
           64'h1000, 64'h0, 8'h00, 64'hFFFF_FFFF_CAFE_F00D);
`endif

    for (int n = 0; n < 40; n++) begin
      st = 1'($urandom_range(0, 1));
      f3 = st ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
      addr = {$urandom, $urandom};
`ifdef LSU_MISALIGN_TRAP_EN
      addr = addr & ~((64'd1 << f3[1:0]) - 64'd1);
`endif
      begin
        logic [63:0] wd, rdv;
        wd  = {$urandom, $urandom};
        rdv = {$urandom, $urandom};
        model(st, f3, addr, wd, rdv, ea, ew, em, eb);
        access($sformatf("rnd%0d", n), st, f3, addr, wd, rdv, 5'($urandom),
               int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), ea, ew, em, eb);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
